// File: rtl/gfx_mat_pair_loader.sv
// Matrix-pair loader: deserializes 32-bit fp words into a 4x4 (a, b) pair
// and presents it on a valid/ready handshake for the matrix multiplier.
// A double buffer lets the next pair assemble while the current pair waits.
// An optional keep_a mode sends b only and reuses the last assembled a.

package gfx_defs;
  typedef logic [31:0] fp;
  typedef fp   [3:0]   vec4;
  typedef vec4 [3:0]   mat4;
endpackage

module gfx_mat_pair_loader
  import gfx_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] word_data,
  input  logic        word_keep_a,
  input  logic        word_valid,
  output logic        word_ready,
  output mat4         a,
  output mat4         b,
  output logic        out_valid,
  input  logic        out_ready
);

  mat4        asm_a_q, asm_a_d;
  mat4        asm_b_q, asm_b_d;
  logic [4:0] cnt_q, cnt_d;
  mat4        out_a_q, out_a_d;
  mat4        out_b_q, out_b_d;
  logic       out_valid_q, out_valid_d;
  logic       pending_q, pending_d;

  logic word_accept;
  logic last_word;
  logic out_free;

  // Words are taken whenever no completed pair is parked in the assembly buffer.
  assign word_ready  = !pending_q;
  assign word_accept = word_valid && !pending_q;
  assign out_free    = !out_valid_q || out_ready;

  assign a         = out_a_q;
  assign b         = out_b_q;
  assign out_valid = out_valid_q;

  // Assembly: write the accepted word into the a/b buffer slot selected by cnt.
  // cnt 0..15 address a, 16..31 address b; keep_a on word 0 jumps straight into b.
  always_comb begin
    asm_a_d   = asm_a_q;
    asm_b_d   = asm_b_q;
    cnt_d     = cnt_q;
    last_word = 1'b0;
    if (word_accept) begin
      if (cnt_q == 5'd0) begin
        if (word_keep_a) begin
          asm_b_d[0][0] = word_data;
          cnt_d         = 5'd17;
        end else begin
          asm_a_d[0][0] = word_data;
          cnt_d         = 5'd1;
        end
      end else begin
        if (!cnt_q[4]) asm_a_d[cnt_q[3:2]][cnt_q[1:0]] = word_data;
        else           asm_b_d[cnt_q[3:2]][cnt_q[1:0]] = word_data;
        // 31 + 1 wraps to 0, ready for the next transfer's first word.
        cnt_d     = cnt_q + 5'd1;
        last_word = (cnt_q == 5'd31);
      end
    end
  end

  // Output side: load a finished pair (directly, or later from pending) when the
  // output register is free; otherwise park it and stall the word stream.
  always_comb begin
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    out_valid_d = out_valid_q;
    pending_d   = pending_q;
    if (last_word && out_free) begin
      // Merged last word comes from the _d path so no extra cycle is needed.
      out_a_d     = asm_a_d;
      out_b_d     = asm_b_d;
      out_valid_d = 1'b1;
    end else if (last_word) begin
      pending_d = 1'b1;
    end else if (pending_q && out_free) begin
      out_a_d     = asm_a_q;
      out_b_d     = asm_b_q;
      out_valid_d = 1'b1;
      pending_d   = 1'b0;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; synchronous reset drops any partial, pending or presented pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      asm_a_q     <= '0;
      asm_b_q     <= '0;
      cnt_q       <= '0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_valid_q <= 1'b0;
      pending_q   <= 1'b0;
    end else begin
      asm_a_q     <= asm_a_d;
      asm_b_q     <= asm_b_d;
      cnt_q       <= cnt_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      out_valid_q <= out_valid_d;
      pending_q   <= pending_d;
    end
  end

endmodule

// File: tb/tb_gfx_mat_pair_loader.sv
// Bench for gfx_mat_pair_loader: directed phases plus randomized traffic,
// with expected pairs queued by the stimulus side and checked by a monitor.
module tb_gfx_mat_pair_loader;
  import gfx_defs::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] word_data;
  logic        word_keep_a;
  logic        word_valid;
  logic        word_ready;
  mat4         a, b;
  logic        out_valid;
  logic        out_ready;

  gfx_mat_pair_loader dut (
    .clk(clk), .rst(rst),
    .word_data(word_data), .word_keep_a(word_keep_a),
    .word_valid(word_valid), .word_ready(word_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int  n_chk  = 0;
  int  n_fail = 0;
  mat4 exp_a_q[$];
  mat4 exp_b_q[$];
  mat4 last_a;          // model: a reused by keep_a transfers
  int  n_pairs_sent = 0;
  int  n_pairs_seen = 0;
  bit  rand_ready = 0;
  bit  zb_phase   = 0;
  int  zb_vcount  = 0;
  bit  held       = 0;
  mat4 held_a, held_b;

  task automatic chk(input string name, input logic [511:0] got, input logic [511:0] expv);
    n_chk++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, expv);
    end
  endtask

  // Monitor: pop and compare on every output handshake; check hold stability.
  always @(negedge clk) begin
    if (rst) begin
      held = 0;
    end else begin
      if (held && out_valid) begin
        chk("hold_a", a, held_a);
        chk("hold_b", b, held_b);
      end
      held = 0;
      if (zb_phase) begin
        chk("zb_word_ready", {511'd0, word_ready}, 512'd1);
        if (out_valid) zb_vcount++;
      end
      if (out_valid && out_ready) begin
        n_pairs_seen++;
        if (exp_a_q.size() == 0) begin
          chk("unexpected_pair", {511'd0, out_valid}, 512'd0);
        end else begin
          chk("pair_a", a, exp_a_q.pop_front());
          chk("pair_b", b, exp_b_q.pop_front());
        end
      end else if (out_valid) begin
        held   = 1;
        held_a = a;
        held_b = b;
      end
    end
  end

  // Random backpressure when enabled.
  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 2) != 0);
  end

  task automatic send_word(input logic [31:0] d, input logic k, input bit gaps);
    int  n = 0;
    bit  done = 0;
    if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    word_data = d; word_keep_a = k; word_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (word_ready) done = 1;
      @(posedge clk);
      n++;
      if (!done && n > 3000) begin
        chk("word_timeout", 512'd0, 512'd1);
        done = 1;
      end
    end
    #1 word_valid = 1'b0; word_keep_a = 1'b0;
  endtask

  // One transfer; expected pair derived from element order rule mat[k/4][k%4].
  task automatic send_pair(input bit keep, input logic [31:0] base, input bit rnd, input bit gaps);
    logic [31:0] w [32];
    mat4 ea, eb;
    int  nw = keep ? 16 : 32;
    ea = last_a; eb = '0;
    for (int k = 0; k < nw; k++) begin
      w[k] = rnd ? $urandom : base + k;
      if (keep)        eb[k/4][k%4]       = w[k];
      else if (k < 16) ea[k/4][k%4]       = w[k];
      else             eb[(k-16)/4][k%4]  = w[k];
    end
    last_a = ea;
    exp_a_q.push_back(ea);
    exp_b_q.push_back(eb);
    n_pairs_sent++;
    for (int k = 0; k < nw; k++)
      send_word(w[k], (k == 0) ? keep : (rnd ? 1'($urandom) : 1'b0), gaps);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_a_q.delete();
    exp_b_q.delete();
    n_pairs_sent = 0;
    n_pairs_seen = 0;
    last_a = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int words;
    mat4 p1a, p1b;
    rst = 1'b1; word_data = '0; word_keep_a = 1'b0; word_valid = 1'b0; out_ready = 1'b1;
    last_a = '0;
    @(posedge clk); #1;
    do_reset();

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", {511'd0, out_valid}, 512'd0);
    chk("rst_word_ready", {511'd0, word_ready}, 512'd1);
    chk("rst_a", a, 512'd0);
    chk("rst_b", b, 512'd0);
    @(posedge clk); #1;

    // Full load: valid rises the cycle after word 31, one handshake
    send_pair(0, 32'h3F80_0000, 0, 0);
    @(negedge clk);
    chk("full_valid_rise", {511'd0, out_valid}, 512'd1);
    @(negedge clk);
    chk("full_valid_fall", {511'd0, out_valid}, 512'd0);
    chk("full_one_hs", 512'(n_pairs_seen), 512'd1);
    @(posedge clk); #1;

    // keep_a reuse of the previous a
    send_pair(1, 32'h4000_0000, 0, 0);
    idle(3);

    // keep_a right after reset uses an all-zero a
    do_reset();
    send_pair(1, 32'h4000_0000, 0, 0);
    @(negedge clk);
    chk("keep_after_rst_a", a, 512'd0);
    idle(3);

    // Backpressure: pair 1 held while pair 2 fully streams in
    out_ready = 1'b0;
    send_pair(0, 32'h1000_0000, 1, 0);
    p1a = exp_a_q[exp_a_q.size()-1];
    p1b = exp_b_q[exp_b_q.size()-1];
    send_pair(0, 32'h2000_0000, 1, 0);
    @(negedge clk);
    chk("bp_word_ready_low", {511'd0, word_ready}, 512'd0);
    chk("bp_out_valid", {511'd0, out_valid}, 512'd1);
    chk("bp_a_pair1", a, p1a);
    chk("bp_b_pair1", b, p1b);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);              // pair 1 handshakes here
    @(negedge clk);              // pair 2 presented, words flow again
    chk("bp_word_ready_back", {511'd0, word_ready}, 512'd1);
    chk("bp_pair2_valid", {511'd0, out_valid}, 512'd1);
    idle(3);

    // Zero-bubble: three continuous full pairs
    zb_vcount = 0;
    zb_phase = 1;
    for (int p = 0; p < 3; p++) send_pair(0, 32'h5000_0000 + 32'(p * 64), 0, 0);
    idle(2);
    zb_phase = 0;
    chk("zb_valid_cycles", 512'(zb_vcount), 512'd3);
    idle(2);

    // Mid-transfer reset after 20 words
    for (int k = 0; k < 20; k++) send_word(32'hDEAD_0000 + k, 1'b0, 0);
    do_reset();
    @(negedge clk);
    chk("midrst_out_valid", {511'd0, out_valid}, 512'd0);
    chk("midrst_a", a, 512'd0);
    chk("midrst_b", b, 512'd0);
    @(posedge clk); #1;
    send_pair(0, 32'h6000_0000, 0, 0);
    idle(3);

    // Random stalls over ~1000 words
    rand_ready = 1;
    words = 0;
    while (words < 1000) begin
      bit keep = ($urandom_range(0, 2) == 0);
      send_pair(keep, 32'h0, 1, 1);
      words += keep ? 16 : 32;
    end
    rand_ready = 0;
    out_ready = 1'b1;
    idle(10);
    chk("drain_queue_empty", 512'(exp_a_q.size()), 512'd0);
    chk("pairs_in_out", 512'(n_pairs_seen), 512'(n_pairs_sent));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
